// File: rtl/frac_clk_divider.sv
// Fractional-N clock divider. The half-period of nclk averages an unsigned
// INT.FRAC fixed-point factor. Each half's length is the integer part of the
// factor plus the carry of a fractional accumulator. A shadow register, loaded
// through a valid/ready handshake, is swapped in only at a rising-edge boundary
// so that the output never shows a runt pulse. The enable stops the output
// cleanly at low.
module frac_clk_divider #(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8,
  parameter logic [INT_BITS+FRAC_BITS-1:0] RESET_FACTOR = 16'h0400
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          en,
  input  logic [INT_BITS+FRAC_BITS-1:0] in_factor,
  input  logic                          factor_valid,
  output logic                          factor_ready,
  output logic                          nclk,
  output logic                          nclk_rise,
  output logic                          factor_applied
);

  localparam int W = INT_BITS + FRAC_BITS;

  // A factor whose integer part is zero behaves as exactly 1.0.
  function automatic logic [W-1:0] effective(input logic [W-1:0] f);
    logic [W-1:0] one;
    one = '0;
    one[FRAC_BITS] = 1'b1;
    if (f[W-1:FRAC_BITS] == '0) begin
      return one;
    end
    return f;
  endfunction

  // Returns {counter load (len-1), new accumulator} for one half-period.
  // The factor must already be effective (integer part >= 1), so len-1 never
  // underflows, and len-1 is at most 2^INT_BITS-1, which fits INT_BITS bits.
  function automatic logic [W-1:0] half_calc(input logic [W-1:0] f,
                                             input logic [FRAC_BITS-1:0] a);
    logic [FRAC_BITS:0]  sum;
    logic [INT_BITS-1:0] load;
    sum  = {1'b0, a} + {1'b0, f[FRAC_BITS-1:0]};
    load = f[W-1:FRAC_BITS] - INT_BITS'(1) + INT_BITS'(sum[FRAC_BITS]);
    return {load, sum[FRAC_BITS-1:0]};
  endfunction

  localparam logic [W-1:0] RESET_EFF  = effective(RESET_FACTOR);
  localparam logic [W-1:0] RESET_CALC = half_calc(RESET_EFF, '0);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STOP_PEND = 2'd1,
    IDLE      = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [INT_BITS-1:0] cnt_reg, cnt_next;
  logic [FRAC_BITS-1:0] acc_reg, acc_next;
  logic [W-1:0]        active_reg, active_next;
  logic [W-1:0]        shadow_reg, shadow_next;
  logic                shadow_full_reg, shadow_full_next;
  logic                nclk_reg, nclk_next;
  logic                rise_reg, rise_next;
  logic                applied_reg, applied_next;

  logic [W-1:0] shadow_eff;
  logic [W-1:0] calc_cont;    // continue the running sequence
  logic [W-1:0] calc_fresh;   // restart the active factor with acc=0
  logic [W-1:0] calc_shadow;  // first half of a newly applied factor

  assign shadow_eff  = effective(shadow_reg);
  assign calc_cont   = half_calc(active_reg, acc_reg);
  assign calc_fresh  = half_calc(active_reg, '0);
  assign calc_shadow = half_calc(shadow_eff, '0);

  // Next-state, counter, accumulator, handshake and strobe logic.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    acc_next         = acc_reg;
    active_next      = active_reg;
    shadow_next      = shadow_reg;
    shadow_full_next = shadow_full_reg;
    nclk_next        = nclk_reg;
    rise_next        = 1'b0;
    applied_next     = 1'b0;

    // Shadow accepts a new factor only while empty; the source must hold.
    if (factor_valid && !shadow_full_reg) begin
      shadow_next      = in_factor;
      shadow_full_next = 1'b1;
    end

    unique case (state_reg)
      RUN: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - INT_BITS'(1);
          if (nclk_reg && !en) begin
            state_next = STOP_PEND;
          end
        end else if (nclk_reg) begin
          // Falling toggle.
          nclk_next = 1'b0;
          {cnt_next, acc_next} = calc_cont;
          if (!en) begin
            state_next = IDLE;
            acc_next   = '0;
          end
        end else if (!en) begin
          // Low half finished while disabled: park without rising.
          state_next = IDLE;
          acc_next   = '0;
        end else begin
          // Rising toggle: the only point where a new factor may take over.
          nclk_next = 1'b1;
          rise_next = 1'b1;
          if (shadow_full_reg) begin
            active_next          = shadow_eff;
            {cnt_next, acc_next} = calc_shadow;
            applied_next         = 1'b1;
            shadow_full_next     = 1'b0;
          end else begin
            {cnt_next, acc_next} = calc_cont;
          end
        end
      end

      STOP_PEND: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - INT_BITS'(1);
          if (en) begin
            state_next = RUN;
          end
        end else begin
          nclk_next = 1'b0;
          {cnt_next, acc_next} = calc_cont;
          if (en) begin
            state_next = RUN;
          end else begin
            state_next = IDLE;
            acc_next   = '0;
          end
        end
      end

      IDLE: begin
        nclk_next = 1'b0;
        acc_next  = '0;
        if (en) begin
          // Restart with a fresh low half; a pending shadow takes over here.
          state_next = RUN;
          if (shadow_full_reg) begin
            active_next          = shadow_eff;
            {cnt_next, acc_next} = calc_shadow;
            applied_next         = 1'b1;
            shadow_full_next     = 1'b0;
          end else begin
            {cnt_next, acc_next} = calc_fresh;
          end
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg       <= RUN;
      cnt_reg         <= RESET_CALC[W-1:FRAC_BITS];
      acc_reg         <= '0;
      active_reg      <= RESET_EFF;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      nclk_reg        <= 1'b0;
      rise_reg        <= 1'b0;
      applied_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      acc_reg         <= acc_next;
      active_reg      <= active_next;
      shadow_reg      <= shadow_next;
      shadow_full_reg <= shadow_full_next;
      nclk_reg        <= nclk_next;
      rise_reg        <= rise_next;
      applied_reg     <= applied_next;
    end
  end

  assign nclk           = nclk_reg;
  assign nclk_rise      = rise_reg;
  assign factor_applied = applied_reg;
  assign factor_ready   = ~shadow_full_reg;

endmodule

// File: tb/tb_frac_clk_divider.sv
// Directed bench for frac_clk_divider: default timing, fractional factors,
// zero-integer clamping, back-to-back loads, enable stop/restart and
// mid-operation reset. Outputs are sampled on the falling clock edge.
module tb_frac_clk_divider;

  logic        clk = 1'b0;
  logic        nreset;
  logic        en;
  logic [15:0] in_factor;
  logic        factor_valid;
  logic        factor_ready;
  logic        nclk;
  logic        nclk_rise;
  logic        factor_applied;

  int vectors = 0;
  int miscompares = 0;

  frac_clk_divider #(
    .INT_BITS(8),
    .FRAC_BITS(8),
    .RESET_FACTOR(16'h0400)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .en(en),
    .in_factor(in_factor),
    .factor_valid(factor_valid),
    .factor_ready(factor_ready),
    .nclk(nclk),
    .nclk_rise(nclk_rise),
    .factor_applied(factor_applied)
  );

  always #5 clk = ~clk;

  // Counts falling-edge samples until nclk reaches lvl (bounded).
  task automatic wait_level(input logic lvl, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (nclk === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_applied(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (factor_applied === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Presents a factor and holds it until the transfer edge has passed.
  task automatic load_factor(input logic [15:0] f, output bit ok);
    bit xfer;
    ok = 1'b0;
    in_factor = f;
    factor_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      xfer = factor_ready;
      @(negedge clk);
      if (xfer) begin
        ok = 1'b1;
        break;
      end
    end
    factor_valid = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    en = 1'b0;
    factor_valid = 1'b0;
    in_factor = 16'h0000;
    repeat (3) @(negedge clk);
    vectors++;
    if ({nclk, nclk_rise, factor_applied, factor_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_outputs: got nclk/rise/applied/ready=%b want 0001",
               {nclk, nclk_rise, factor_applied, factor_ready});
    end
  endtask

  task automatic test_default();
    int n, rises, applies;
    bit ok;
    nreset = 1'b1;
    en = 1'b1;
    wait_level(1'b1, n, ok);
    vectors++;
    if (!ok || n != 4) begin
      miscompares++;
      $display("FAIL default_first_low: got %0d (ok=%0b) want 4", n, ok);
    end
    vectors++;
    if (nclk_rise !== 1'b1) begin
      miscompares++;
      $display("FAIL default_rise_strobe: got %b want 1", nclk_rise);
    end
    wait_level(1'b0, n, ok);
    vectors++;
    if (!ok || n != 4) begin
      miscompares++;
      $display("FAIL default_high: got %0d want 4", n);
    end
    wait_level(1'b1, n, ok);
    vectors++;
    if (!ok || n != 4) begin
      miscompares++;
      $display("FAIL default_low: got %0d want 4", n);
    end
    rises = 0;
    applies = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (nclk_rise === 1'b1) rises++;
      if (factor_applied === 1'b1) applies++;
    end
    vectors++;
    if (rises != 10 || applies != 0 || factor_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL default_80clk: rises=%0d applies=%0d ready=%b want 10 0 1",
               rises, applies, factor_ready);
    end
  endtask

  task automatic test_frac_2p5();
    int n, rises, highs;
    bit ok;
    load_factor(16'h0280, ok);
    vectors++;
    if (!ok || factor_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_2p5_ready: ok=%0b ready=%b want 1 0", ok, factor_ready);
    end
    wait_applied(ok);
    vectors++;
    if (!ok || nclk_rise !== 1'b1 || nclk !== 1'b1) begin
      miscompares++;
      $display("FAIL apply_2p5: ok=%0b rise=%b nclk=%b want 1 1 1", ok, nclk_rise, nclk);
    end
    wait_level(1'b0, n, ok);
    vectors++;
    if (!ok || n != 2) begin
      miscompares++;
      $display("FAIL 2p5_first_high: got %0d want 2", n);
    end
    wait_level(1'b1, n, ok);
    vectors++;
    if (!ok || n != 3) begin
      miscompares++;
      $display("FAIL 2p5_first_low: got %0d want 3", n);
    end
    rises = 0;
    highs = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (nclk_rise === 1'b1) rises++;
      if (nclk === 1'b1) highs++;
    end
    vectors++;
    if (rises != 1000 || highs != 2000) begin
      miscompares++;
      $display("FAIL 2p5_5000clk: rises=%0d highs=%0d want 1000 2000", rises, highs);
    end
  endtask

  task automatic test_frac_1p332();
    int n, total, mn, mx;
    bit ok, all_ok;
    load_factor(16'h0155, ok);
    wait_applied(all_ok);
    all_ok = all_ok && ok;
    total = 0;
    mn = 1000;
    mx = 0;
    for (int h = 0; h < 256; h++) begin
      wait_level((h % 2 == 0) ? 1'b0 : 1'b1, n, ok);
      if (!ok) all_ok = 1'b0;
      total += n;
      if (n < mn) mn = n;
      if (n > mx) mx = n;
    end
    vectors++;
    if (!all_ok || total < 340 || total > 342) begin
      miscompares++;
      $display("FAIL 1p332_total: got %0d (ok=%0b) want 341 +/-1", total, all_ok);
    end
    vectors++;
    if (mn < 1 || mx > 2) begin
      miscompares++;
      $display("FAIL 1p332_range: min=%0d max=%0d want within 1..2", mn, mx);
    end
  endtask

  task automatic test_clamp();
    int rises, stuck;
    bit ok, ok2;
    logic prev;
    load_factor(16'h0040, ok);
    wait_applied(ok2);
    vectors++;
    if (!ok || !ok2) begin
      miscompares++;
      $display("FAIL clamp_apply: load_ok=%0b apply_ok=%0b want 1 1", ok, ok2);
    end
    rises = 0;
    stuck = 0;
    prev = nclk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nclk_rise === 1'b1) rises++;
      if (nclk === prev) stuck++;
      prev = nclk;
    end
    vectors++;
    if (rises != 10 || stuck != 0) begin
      miscompares++;
      $display("FAIL clamp_toggle: rises=%0d non_toggles=%0d want 10 0", rises, stuck);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, run_len, min_run, n;
    bit pend, ok;
    logic prev, ready_mid;
    in_factor = 16'h0300;
    factor_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (factor_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first_accept: ready=%b want 0", factor_ready);
    end
    in_factor = 16'h0500;
    a1 = -1;
    a2 = -1;
    pend = 1'b0;
    prev = nclk;
    run_len = 1;
    min_run = 1000;
    ready_mid = 1'bx;
    for (int t = 0; t < 300 && a2 < 0; t++) begin
      @(negedge clk);
      if (pend) factor_valid = 1'b0;
      if (nclk !== prev) begin
        if (a1 >= 0 && run_len < min_run) min_run = run_len;
        run_len = 1;
        prev = nclk;
      end else begin
        run_len++;
      end
      if (factor_applied === 1'b1) begin
        if (a1 < 0) a1 = t;
        else a2 = t;
      end
      if (a1 >= 0 && t == a1 + 3) ready_mid = factor_ready;
      pend = factor_valid && factor_ready;
    end
    factor_valid = 1'b0;
    vectors++;
    if (a1 < 0 || a2 < 0 || a2 - a1 != 6) begin
      miscompares++;
      $display("FAIL b2b_apply_spacing: a1=%0d a2=%0d want spacing 6", a1, a2);
    end
    vectors++;
    if (ready_mid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_held_low: got %b want 0", ready_mid);
    end
    vectors++;
    if (min_run != 3) begin
      miscompares++;
      $display("FAIL b2b_no_runt: shortest half=%0d want 3", min_run);
    end
    wait_level(1'b0, n, ok);
    vectors++;
    if (!ok || n != 5 || factor_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_high: got %0d ready=%b want 5 1", n, factor_ready);
    end
  endtask

  task automatic test_stop_restart();
    int n, highs, strobes;
    bit ok, ok2;
    load_factor(16'h0280, ok);
    wait_applied(ok2);
    en = 1'b0;
    wait_level(1'b0, n, ok);
    vectors++;
    if (!ok || !ok2 || n != 2) begin
      miscompares++;
      $display("FAIL stop_high_completes: got %0d want 2", n);
    end
    highs = 0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nclk !== 1'b0) highs++;
      if (nclk_rise !== 1'b0 || factor_applied !== 1'b0) strobes++;
    end
    vectors++;
    if (highs != 0 || strobes != 0 || factor_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_quiet: highs=%0d strobes=%0d ready=%b want 0 0 1",
               highs, strobes, factor_ready);
    end
    en = 1'b1;
    wait_level(1'b1, n, ok);
    vectors++;
    if (!ok || n != 3 || nclk_rise !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_low: got %0d rise=%b want 3 1", n, nclk_rise);
    end
    wait_level(1'b0, n, ok);
    vectors++;
    if (!ok || n != 3) begin
      miscompares++;
      $display("FAIL restart_high: got %0d want 3", n);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit ok;
    wait_level(1'b1, n, ok);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    vectors++;
    if ({nclk, nclk_rise, factor_applied, factor_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %b want 0001",
               {nclk, nclk_rise, factor_applied, factor_ready});
    end
    @(negedge clk);
    nreset = 1'b1;
    wait_level(1'b1, n, ok);
    vectors++;
    if (!ok || n != 4) begin
      miscompares++;
      $display("FAIL midreset_low: got %0d want 4", n);
    end
    wait_level(1'b0, n, ok);
    vectors++;
    if (!ok || n != 4) begin
      miscompares++;
      $display("FAIL midreset_high: got %0d want 4", n);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_frac_2p5();
    test_frac_1p332();
    test_clamp();
    test_back_to_back();
    test_stop_restart();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frac_clk_divider.md
Name: frac_clk_divider

Overview:
- Parametrised fractional-N clock divider; successor to the fixed-width `divider` used in the FM transmitter.
- Runs on the fast carrier clock (e.g. 500 MHz). Produces `nclk`, whose half-period averages an unsigned fixed-point factor.
- Adds a valid/ready factor-load handshake and glitch-free factor switching at period boundaries.
- Adds an enable with a clean stop-at-low, and status strobes for the audio/modulation front-end.

Parameters:
- INT_BITS, 8, integer bits of the factor (unit: clk cycles per nclk half-period).
- FRAC_BITS, 8, fractional bits of the factor.
- RESET_FACTOR, 16'h0400, active factor after reset; width INT_BITS+FRAC_BITS.

Ports:
- clk  in  1  fast clock.
- nreset  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- in_factor  in  INT_BITS+FRAC_BITS  requested half-period, fixed point INT.FRAC.
- factor_valid  in  1  in_factor is valid this cycle.
- factor_ready  out  1  shadow register is empty; a transfer occurs when valid and ready are both high.
- nclk  out  1  divided clock.
- nclk_rise  out  1  one-cycle strobe in the cycle nclk goes 0->1.
- factor_applied  out  1  one-cycle strobe when the shadow factor becomes the active factor.

Behaviour:
- Reset (async, nreset=0):
  - nclk=0, nclk_rise=0, factor_applied=0, factor_ready=1.
  - active=RESET_FACTOR, acc=0, shadow empty, state=RUN.
  - Half-counter is loaded with the first low-half length.
- Effective factor:
  - If the integer part of a factor is 0, the whole factor is treated as 1.0 (integer 1, fraction 0).
  - This applies to RESET_FACTOR and to loaded values.
- Half-length computation:
  - sum = acc + frac (FRAC_BITS+1 bits).
  - len = int + carry(sum).
  - acc <= sum[FRAC_BITS-1:0].
  - The computation is performed once per half-period, at each toggle, for the half starting next.
  - Long-run mean half-period = factor exactly; duty is near 50%, and the two halves differ by at most 1 clk.
- Counting:
  - The counter is loaded with len-1 and decrements each clk.
  - At count 0, nclk toggles on the next edge and the next len is loaded.
  - nclk is registered; no combinational path to the output.
- Factor handshake:
  - A transfer writes the shadow register and drops factor_ready.
  - While the shadow is full, factor_ready=0 and further valids are ignored (source must hold).
- Factor application:
  - Happens only at a rising-edge toggle (period boundary).
  - If the shadow is full: active<=shadow, acc<=0, the high half uses the new factor, factor_applied pulses with nclk_rise, and the shadow is freed (factor_ready=1 the following cycle).
  - Simultaneous free and new transfer in the same cycle cannot occur, because ready is low during that cycle.
- State machine (RUN, STOP_PEND, IDLE):
  - RUN: en=0 at any time -> STOP_PEND if nclk=1, or IDLE at the end of the current low half.
  - STOP_PEND: counting continues; at the falling toggle nclk<=0 -> IDLE.
  - IDLE: nclk=0, counter frozen, acc reset to 0, no strobes. Handshake still accepted; a pending shadow is applied at the restart boundary.
  - IDLE to RUN: en=1 starts a fresh low half of length computed from the active (or applied) factor.
  - en re-asserted during STOP_PEND: return to RUN without interrupting the current half.
- Strobes: nclk_rise and factor_applied are never high for two consecutive cycles, and never high in IDLE.
- Mid-operation reset: all state clears immediately. nclk may be truncated (permitted), and output restarts from reset values.
- Widths: all arithmetic is unsigned; carry is never lost; len max = 2^INT_BITS.

Test Plan:
- Default reset, en=1, no loads -> nclk low 4, high 4, period 8 clk; nclk_rise once per 8 clk; factor_ready=1.
- Load 16'h0280 (2.5) -> at next rising boundary factor_applied=1; halves alternate 2,3 starting from the high half; period 5; 1000 periods total 5000 clk.
- Load 16'h0155 (~1.332) -> over 256 half-periods the total equals floor(256*0x155/256)±1 clk, and no half-period is <1 or >2.
- Load 16'h0040 (int 0) -> clamped to 1.0: nclk toggles every clk, period 2.
- Two back-to-back loads (0x0300, 0x0500) -> first accepted; factor_ready=0 until applied at the next rise; second held by the source, then applied one full period later; no runt pulse.
- Drop en while nclk=1 -> high half completes, nclk stays 0; re-raise en -> first low half uses the active factor with acc=0.
- Assert nreset mid-period -> nclk=0 immediately; restart matches default reset timing.
